// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Bit counter width; WIDTH-1 is the largest value it ever holds.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_full_addr.sv
// One-bit full adder cell, reused every cycle by the serial subtractor.
module full_addr (
   input  logic in1,
   input  logic in2,
   input  logic cin,
   output logic sum,
   output logic carry
);

   assign sum   = in1 ^ in2 ^ cin;
   assign carry = (in1 & in2) | (in1 & cin) | (in2 & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b: one full-adder cell with b inverted and carry-in 1, LSB first,
// WIDTH cycles per result.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output state_t           fsm_state
);

   localparam int CNT_W = cnt_width(WIDTH);

   // Handshake: start is a request taken on any rising edge where the FSM is IDLE
   // (including the done cycle); a and b are sampled only on that edge. start is
   // ignored while busy. done pulses for one cycle when diff/borrow/ovf update.

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic [CNT_W-1:0] count;
   logic             carry;
   logic             a_msb;
   logic             b_msb;
   logic             fa_sum;
   logic             fa_carry;
   logic             last;

   full_addr u_fa (
      .in1   (a_sh[0]),
      .in2   (~b_sh[0]),
      .cin   (carry),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   assign last     = (state == SHIFT) && (count == CNT_W'(WIDTH - 1));
   assign res_next = (res_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = SHIFT;
         SHIFT:   if (last)  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         count  <= '0;
         carry  <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
         ovf    <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               a_sh   <= a;
               b_sh   <= b;
               res_sh <= '0;
               carry  <= 1'b1;
               count  <= '0;
               a_msb  <= a[WIDTH-1];
               b_msb  <= b[WIDTH-1];
            end
         end else begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next;
            carry  <= fa_carry;
            if (last) begin
               // The bit produced on this edge is the result MSB.
               count  <= '0;
               diff   <= res_next;
               borrow <= ~fa_carry;
               ovf    <= (a_msb != b_msb) && (fa_sum != a_msb);
               done   <= 1'b1;
            end else begin
               count <= count + CNT_W'(1);
            end
         end
      end
   end

   assign busy      = (state == SHIFT);
   assign fsm_state = state;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial W-bit unsigned/two's-complement subtractor computing diff = a - b, one bit per clock, LSB first.
- Reuses a single 1-bit full-adder cell with b inverted and an initial carry-in of 1. This trades the area of a ripple-carry subtractor for W cycles of latency.
- Sits beside the combinational ripple-carry adder datapath and provides its inverse operation behind a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only while idle.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when diff, borrow and ovf are updated.
- diff  output  WIDTH  a - b mod 2^WIDTH; holds until the next completion.
- borrow  output  1  1 when a < b (unsigned), i.e. the inverted final carry.
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock (clk); reset rst_n is asynchronous and active-low.
  - Asserting rst_n low immediately forces state=IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, the internal shift registers to 0, carry=0 and count=0.
  - Reset mid-operation aborts the operation with no done pulse.
  - Release is synchronous to clk.
- States: IDLE and SHIFT.
- IDLE:
  - If start=1 at an edge: latch a and b into shift registers, set carry=1 and count=0, go to SHIFT, busy=1.
  - Otherwise remain in IDLE.
- SHIFT, on each edge:
  - Bit s = a_sh[0] ^ ~b_sh[0] ^ carry.
  - carry <= majority(a_sh[0], ~b_sh[0], carry).
  - Shift s into the MSB of the result register; shift a_sh and b_sh right by one.
  - count <= count + 1.
- Completion:
  - On the edge where count == WIDTH-1, the last bit is computed.
  - On that same edge: diff <= completed result, borrow <= ~carry_out, ovf <= per the rule above using the latched operand MSBs, done <= 1, busy <= 0, state <= IDLE.
- Latency: start accepted at edge E0, done high in the cycle following edge E0+WIDTH, i.e. WIDTH cycles after acceptance.
- start handling:
  - start while busy=1 is ignored, and the a/b inputs are not sampled.
  - start during the done cycle is accepted (back-to-back supported, throughput of one result per WIDTH+1 cycles).
- done is high for exactly one cycle; it never asserts without a preceding accepted start.
- Wrap-around: diff is modulo 2^WIDTH, so 0x00 - 0x01 gives 0xFF with borrow=1.
- Outputs diff, borrow and ovf change only on the completion edge or on reset; they are stable while busy.
- count is sized to clog2(WIDTH) bits and never exceeds WIDTH-1.

Decomposition:
- Shared package serial_sub_pkg:
  - state enum {IDLE, SHIFT}.
  - Default WIDTH constant.
  - CNT_W = clog2(WIDTH) helper.
- One natural sub-module: the team's existing 1-bit full_addr cell.
  - Inputs: in1 = a_sh[0], in2 = ~b_sh[0], cin = carry register.
  - Outputs: sum feeds the result shift-in; carry feeds the carry register.

Test Plan:
- a=0x05, b=0x03, start for 1 cycle -> busy for 8 cycles, then done=1 for 1 cycle with diff=0x02, borrow=0, ovf=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow=1, ovf=0; a=0x00, b=0x01 -> diff=0xFF, borrow=1.
- a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
- Start with a=0x10, b=0x01, then pulse start with a=0xAA, b=0x55 at cycle 3 -> second start ignored, diff=0x0F; a start asserted in the done cycle is accepted and its result arrives 9 cycles later.
- rst_n low at cycle 4 of an operation -> busy, done, diff, borrow and ovf all 0 immediately, no done pulse; after release, a=0xFF, b=0xFF gives diff=0x00, borrow=0, ovf=0.
- Random a/b with 1000 iterations against a reference model -> diff, borrow and ovf match; done appears exactly WIDTH cycles after each acceptance.
